jtag_unlock_seq: RTL and testbench
==================================

JTAG_UNLOCK_SEQ -- requirements
Module: jtag_unlock_seq

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 6, number of unlock words produced.
REQ-002 SHALL have parameter MAX_ATTEMPTS, default 3, consecutive failed key checks that trigger lockout.
REQ-003 SHALL have parameter LOCKOUT_CYCLES, default 16, lockout duration in clocks.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port req_valid_i, input, 1, unlock request valid.
REQ-007 SHALL have port req_ready_o, output, 1, request accepted when valid and ready are both high.
REQ-008 SHALL have port req_word_i, input, 3, index of the word to unlock.
REQ-009 SHALL have port req_key_i, input, 32, key presented by the debugger.
REQ-010 SHALL have port ref_key_i, input, 32, fused reference key, static after reset.
REQ-011 SHALL have port relock_i, input, 1, clears all unlock words.
REQ-012 SHALL have port jtag_unlock_o, output, NUM_WORDS x 32, unlock words consumed by the register-lock stage.
REQ-013 SHALL have port rsp_valid_o, output, 1, one-cycle response pulse.
REQ-014 SHALL have port rsp_ok_o, output, 1, grant result; meaningful only with rsp_valid_o.
REQ-015 SHALL have port locked_out_o, output, 1, high while in LOCKOUT.

Function
REQ-016 SHALL implement FSM states IDLE, CHECK, RESP, LOCKOUT.
REQ-017 SHALL drive req_ready_o high only in IDLE.
REQ-018 SHALL register req_word_i and req_key_i on the acceptance edge and move IDLE->CHECK.
REQ-019 SHALL compare the captured key with ref_key_i in CHECK (full 32-bit equality) and move CHECK->RESP.
REQ-020 SHALL assert rsp_valid_o for exactly the RESP cycle: acceptance at edge N gives a rsp_valid_o pulse during cycle N+2.
REQ-021 SHALL treat a match with word index < NUM_WORDS as a grant: rsp_ok_o=1, jtag_unlock_o[idx] becomes 32'h0000_0001 on the edge entering RESP, and the fail counter clears.
REQ-022 SHALL treat a key mismatch as a failure: rsp_ok_o=0, no word changes, and the fail counter increments with saturation at MAX_ATTEMPTS.
REQ-023 SHALL answer an index >= NUM_WORDS with rsp_ok_o=0, leave all words unchanged, and not change the fail counter.
REQ-024 SHALL move RESP->LOCKOUT when the fail counter equals MAX_ATTEMPTS, otherwise RESP->IDLE.
REQ-025 SHALL hold LOCKOUT for exactly LOCKOUT_CYCLES cycles, then clear the fail counter and return to IDLE.
REQ-026 SHALL keep req_ready_o low and locked_out_o high during LOCKOUT.
REQ-027 SHALL set every jtag_unlock_o word to 0 on the edge after relock_i is high, in any state.
REQ-028 SHALL give relock_i priority over a grant in the same cycle; the word stays 0 and rsp_ok_o still reports 1.
REQ-029 SHALL leave the FSM state and the fail counter unaffected by relock_i.
REQ-030 SHALL keep jtag_unlock_o unchanged when a word that is already unlocked is granted again.

Reset
REQ-031 SHALL, on rst_i high, immediately (asynchronously) drive the following values: state IDLE; all jtag_unlock_o words 0; rsp_valid_o=0; rsp_ok_o=0; locked_out_o=0; fail counter 0; lockout timer 0.
REQ-032 SHALL abandon any in-flight request when reset is asserted mid-operation; no response is issued after release.
REQ-033 SHALL drive req_ready_o high in the first cycle after rst_i deasserts.

Structure
REQ-034 SHALL place the state enum, the UNLOCK_VAL constant (32'h1), and the LOCK_VAL constant (32'h0) in the shared package jtag_unlock_pkg.
REQ-035 SHALL implement the lockout countdown in one sub-module, lockout_timer, with inputs start and clk_i/rst_i and output done.

Verification
REQ-036 SHALL cover the following scenario: ref=32'hA5A5_0001, request word 2 with key 32'hA5A5_0001 at edge N -> rsp_valid and rsp_ok=1 in cycle N+2, jtag_unlock_o[2]=1, all other words 0.
REQ-037 SHALL cover the following scenario: three consecutive wrong keys (32'h0) -> three rsp_ok=0 pulses, then locked_out_o high for exactly 16 cycles with req_ready_o low, then IDLE with the fail counter at 0.
REQ-038 SHALL cover the following scenario: two wrong keys, one correct key on word 0, two wrong keys -> no lockout; jtag_unlock_o[0]=1.
REQ-039 SHALL cover the following scenario: request word 7 with the correct key -> rsp_ok=0, no words change, the fail counter does not change.
REQ-040 SHALL cover the following scenario: relock_i asserted in the same cycle as a grant to word 4 -> rsp_ok=1, jtag_unlock_o[4]=0, all words 0.
REQ-041 SHALL cover the following scenario: rst_i pulsed during CHECK -> outputs immediately at reset values, no rsp_valid_o after release, req_ready_o=1 in the next cycle.

Source files
------------

// File: rtl/jtag_unlock_pkg.sv
// ---------------------------------------------------------------------------
// jtag_unlock_pkg
// Shared definitions for the JTAG unlock sequencer: the FSM state encoding
// and the two values an unlock word can take. The register-lock stage
// treats a word of UNLOCK_VAL as "debug access open" and LOCK_VAL as
// "debug access closed".
// ---------------------------------------------------------------------------
package jtag_unlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_RESP    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_e;

    localparam logic [31:0] UNLOCK_VAL = 32'h0000_0001;
    localparam logic [31:0] LOCK_VAL   = 32'h0000_0000;

endpackage : jtag_unlock_pkg

// File: rtl/jtag_unlock_seq_lockout_timer.sv
// ---------------------------------------------------------------------------
// lockout_timer
// Counts out the lockout window after too many failed key checks.
//
// Ports
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   start  : one-cycle pulse; the window begins on the following edge
//   done   : high during the last cycle of the window
//
// When start is sampled, the counter loads LOCKOUT_CYCLES-1 and counts down
// to zero. done is asserted while the counter sits at zero, so the window
// covers exactly LOCKOUT_CYCLES cycles including the cycle done is high.
// ---------------------------------------------------------------------------
module lockout_timer #(
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start,
    output logic done
);

    localparam int CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;

    // Load on start, otherwise count down while the window is open and
    // close it once the final cycle has been spent.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            cnt_d    = CNT_W'(LOCKOUT_CYCLES - 1);
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Counter state; reset leaves the timer idle at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign done = active_q && (cnt_q == '0);

endmodule : lockout_timer

// File: rtl/jtag_unlock_seq.sv
// ---------------------------------------------------------------------------
// jtag_unlock_seq
// Grants debug unlock words in response to key-checked requests from the
// debugger, and locks the requester out for a while after repeated bad keys.
//
// Ports
//   clk_i          : clock, rising edge
//   rst_i          : asynchronous active-high reset
//   req_valid_i    : unlock request valid
//   req_ready_o    : high only in IDLE; request taken when valid && ready
//   req_word_i     : index of the word to unlock
//   req_key_i      : key presented by the debugger
//   ref_key_i      : fused reference key (static after reset)
//   relock_i       : clears every unlock word on the next edge
//   jtag_unlock_o  : NUM_WORDS packed 32-bit unlock words, word 0 in LSBs
//   rsp_valid_o    : one-cycle response pulse
//   rsp_ok_o       : grant result, meaningful with rsp_valid_o
//   locked_out_o   : high while the lockout window is running
//
// Flow: IDLE accepts and captures the request, CHECK compares the captured
// key and commits the result (words, fail counter, response flops) on the
// edge into RESP, RESP pulses the response and decides whether the fail
// counter has reached the lockout threshold.
// ---------------------------------------------------------------------------
module jtag_unlock_seq #(
    parameter int NUM_WORDS      = 6,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [2:0]              req_word_i,
    input  logic [31:0]             req_key_i,
    input  logic [31:0]             ref_key_i,
    input  logic                    relock_i,
    output logic [NUM_WORDS*32-1:0] jtag_unlock_o,
    output logic                    rsp_valid_o,
    output logic                    rsp_ok_o,
    output logic                    locked_out_o
);

    import jtag_unlock_pkg::*;

    localparam int FAIL_W = $clog2(MAX_ATTEMPTS + 1);

    state_e                       state_q, state_d;
    logic [2:0]                   word_q, word_d;
    logic [31:0]                  key_q, key_d;
    logic [NUM_WORDS-1:0][31:0]   words_q, words_d;
    logic [FAIL_W-1:0]            fail_q, fail_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic                         rsp_ok_q, rsp_ok_d;
    logic                         locked_out_q, locked_out_d;

    logic                         timer_start;
    logic                         timer_done;
    logic                         word_in_range;

    assign word_in_range = ({29'd0, word_q} < 32'(NUM_WORDS));

    lockout_timer #(
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) u_lockout_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .start (timer_start),
        .done  (timer_done)
    );

    // Next-state and next-output logic. The grant/fail decision is made in
    // CHECK so that its effects land on the same edge that enters RESP.
    // An out-of-range index is answered with a refusal but is not counted
    // as a failed attempt, whatever the key was.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        key_d       = key_q;
        words_d     = words_q;
        fail_d      = fail_q;
        rsp_valid_d = 1'b0;
        rsp_ok_d    = 1'b0;
        timer_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    word_d  = req_word_i;
                    key_d   = req_key_i;
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                if (word_in_range) begin
                    if (key_q == ref_key_i) begin
                        rsp_ok_d        = 1'b1;
                        words_d[word_q] = UNLOCK_VAL;
                        fail_d          = '0;
                    end else if (fail_q < FAIL_W'(MAX_ATTEMPTS)) begin
                        fail_d = fail_q + FAIL_W'(1);
                    end
                end
            end

            ST_RESP: begin
                if (fail_q == FAIL_W'(MAX_ATTEMPTS)) begin
                    state_d     = ST_LOCKOUT;
                    timer_start = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LOCKOUT: begin
                if (timer_done) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Relock wins over a grant landing on the same edge, but leaves the
        // FSM and fail counter alone.
        if (relock_i) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                words_d[i] = LOCK_VAL;
            end
        end

        locked_out_d = (state_d == ST_LOCKOUT);
    end

    // All sequencer state and registered outputs. Reset drops any request
    // in flight and relocks every word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            word_q       <= '0;
            key_q        <= '0;
            words_q      <= '0;
            fail_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_ok_q     <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            key_q        <= key_d;
            words_q      <= words_d;
            fail_q       <= fail_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_ok_q     <= rsp_ok_d;
            locked_out_q <= locked_out_d;
        end
    end

    assign req_ready_o   = (state_q == ST_IDLE);
    assign jtag_unlock_o = words_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_ok_o      = rsp_ok_q;
    assign locked_out_o  = locked_out_q;

endmodule : jtag_unlock_seq

// File: tb/tb_jtag_unlock_seq.sv
// ---------------------------------------------------------------------------
// tb_jtag_unlock_seq
// Directed bench for the JTAG unlock sequencer with default parameters
// (6 words, 3 attempts, 16-cycle lockout). Expected values are written out
// by hand in the sequence below.
// ---------------------------------------------------------------------------
module tb_jtag_unlock_seq;

    localparam int NW = 6;
    localparam int WW = NW * 32;
    localparam logic [31:0] REF_KEY = 32'hA5A5_0001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_word = '0;
    logic [31:0]   req_key = '0;
    logic [31:0]   ref_key = REF_KEY;
    logic          relock = 1'b0;
    logic [WW-1:0] unlock_words;
    logic          rsp_valid;
    logic          rsp_ok;
    logic          locked_out;

    int            checks = 0;
    int            errors = 0;
    logic [WW-1:0] exp_words = '0;
    logic          flag;

    jtag_unlock_seq dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_word_i    (req_word),
        .req_key_i     (req_key),
        .ref_key_i     (ref_key),
        .relock_i      (relock),
        .jtag_unlock_o (unlock_words),
        .rsp_valid_o   (rsp_valid),
        .rsp_ok_o      (rsp_ok),
        .locked_out_o  (locked_out)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [WW-1:0] observed,
                               input logic [WW-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One full request: accept, CHECK, RESP pulse, back out of RESP.
    // relock_in_check raises relock_i for the CHECK cycle so it coincides
    // with the grant edge.
    task automatic applyStimulus(input logic [2:0] word, input logic [31:0] key,
                                 input logic relock_in_check, input logic exp_ok,
                                 input string tag);
        checkOutput({tag, "_ready"}, WW'(req_ready), WW'(1));
        req_valid = 1'b1;
        req_word  = word;
        req_key   = key;
        tick();
        req_valid = 1'b0;
        req_key   = 32'hDEAD_BEEF;
        relock    = relock_in_check;
        checkOutput({tag, "_busy"}, WW'(req_ready), WW'(0));
        checkOutput({tag, "_early"}, WW'(rsp_valid), WW'(0));
        tick();
        relock = 1'b0;
        checkOutput({tag, "_valid"}, WW'(rsp_valid), WW'(1));
        checkOutput({tag, "_ok"}, WW'(rsp_ok), WW'(exp_ok));
        tick();
        checkOutput({tag, "_pulse"}, WW'(rsp_valid), WW'(0));
    endtask

    // Count lockout cycles (bounded) and confirm ready stays low throughout.
    task automatic measureLockout(input string tag);
        int   n = 0;
        logic ready_low = 1'b1;
        while (locked_out === 1'b1 && n < 40) begin
            if (req_ready !== 1'b0) ready_low = 1'b0;
            n++;
            tick();
        end
        checkOutput({tag, "_len"}, WW'(n), WW'(16));
        checkOutput({tag, "_readylow"}, WW'(ready_low), WW'(1));
        checkOutput({tag, "_ready_after"}, WW'(req_ready), WW'(1));
    endtask

    initial begin
        // Reset values while reset is held
        #1;
        checkOutput("rst_valid", WW'(rsp_valid), WW'(0));
        checkOutput("rst_ok", WW'(rsp_ok), WW'(0));
        checkOutput("rst_locked", WW'(locked_out), WW'(0));
        checkOutput("rst_words", unlock_words, WW'(0));
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rel_ready", WW'(req_ready), WW'(1));
        tick();
        checkOutput("rel_ready_next", WW'(req_ready), WW'(1));

        // Grant word 2 with the correct key
        applyStimulus(3'd2, REF_KEY, 1'b0, 1'b1, "grant2");
        exp_words[2*32 +: 32] = 32'h1;
        checkOutput("grant2_words", unlock_words, exp_words);

        // Two fails, a grant on word 0, two fails: no lockout
        applyStimulus(3'd1, 32'h0, 1'b0, 1'b0, "mix_f1");
        applyStimulus(3'd3, 32'h0, 1'b0, 1'b0, "mix_f2");
        applyStimulus(3'd0, REF_KEY, 1'b0, 1'b1, "mix_g0");
        applyStimulus(3'd1, 32'h0, 1'b0, 1'b0, "mix_f3");
        applyStimulus(3'd1, 32'h0, 1'b0, 1'b0, "mix_f4");
        checkOutput("mix_nolock", WW'(locked_out), WW'(0));
        exp_words[0 +: 32] = 32'h1;
        checkOutput("mix_words", unlock_words, exp_words);

        // Out-of-range index with the right key: refused, counter untouched
        applyStimulus(3'd7, REF_KEY, 1'b0, 1'b0, "badidx");
        checkOutput("badidx_words", unlock_words, exp_words);
        checkOutput("badidx_nolock", WW'(locked_out), WW'(0));

        // Counter still at 2, so one more bad key locks out
        applyStimulus(3'd1, 32'h0, 1'b0, 1'b0, "third_fail");
        checkOutput("third_locked", WW'(locked_out), WW'(1));
        measureLockout("lock1");

        // Three consecutive wrong keys from a cleared counter
        applyStimulus(3'd5, 32'h0, 1'b0, 1'b0, "w1");
        checkOutput("w1_nolock", WW'(locked_out), WW'(0));
        applyStimulus(3'd5, 32'h0, 1'b0, 1'b0, "w2");
        checkOutput("w2_nolock", WW'(locked_out), WW'(0));
        applyStimulus(3'd5, 32'h0, 1'b0, 1'b0, "w3");
        checkOutput("w3_locked", WW'(locked_out), WW'(1));
        measureLockout("lock2");
        checkOutput("lock2_words", unlock_words, exp_words);

        // Counter cleared after lockout: two fails do not lock out
        applyStimulus(3'd5, 32'h0, 1'b0, 1'b0, "post1");
        applyStimulus(3'd5, 32'h0, 1'b0, 1'b0, "post2");
        checkOutput("post_nolock", WW'(locked_out), WW'(0));
        applyStimulus(3'd5, REF_KEY, 1'b0, 1'b1, "grant5");
        exp_words[5*32 +: 32] = 32'h1;
        checkOutput("grant5_words", unlock_words, exp_words);

        // Re-granting an unlocked word leaves it unchanged
        applyStimulus(3'd5, REF_KEY, 1'b0, 1'b1, "regrant5");
        checkOutput("regrant5_words", unlock_words, exp_words);

        // Relock coinciding with a grant to word 4
        applyStimulus(3'd4, REF_KEY, 1'b1, 1'b1, "relock_grant");
        exp_words = '0;
        checkOutput("relock_grant_words", unlock_words, exp_words);

        // Relock in IDLE: words clear, FSM stays ready
        applyStimulus(3'd1, REF_KEY, 1'b0, 1'b1, "grant1");
        exp_words[1*32 +: 32] = 32'h1;
        checkOutput("grant1_words", unlock_words, exp_words);
        relock = 1'b1;
        tick();
        relock = 1'b0;
        exp_words = '0;
        checkOutput("relock_idle_words", unlock_words, exp_words);
        checkOutput("relock_idle_ready", WW'(req_ready), WW'(1));

        // Relock does not reset the fail counter
        applyStimulus(3'd2, 32'h0, 1'b0, 1'b0, "rf1");
        applyStimulus(3'd2, 32'h0, 1'b0, 1'b0, "rf2");
        relock = 1'b1;
        tick();
        relock = 1'b0;
        applyStimulus(3'd2, 32'h0, 1'b0, 1'b0, "rf3");
        checkOutput("rf3_locked", WW'(locked_out), WW'(1));
        measureLockout("lock3");

        // Reset pulsed during CHECK
        applyStimulus(3'd3, REF_KEY, 1'b0, 1'b1, "grant3");
        exp_words[3*32 +: 32] = 32'h1;
        checkOutput("grant3_words", unlock_words, exp_words);
        req_valid = 1'b1;
        req_word  = 3'd0;
        req_key   = REF_KEY;
        tick();
        req_valid = 1'b0;
        checkOutput("midrst_in_check", WW'(req_ready), WW'(0));
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", WW'(rsp_valid), WW'(0));
        checkOutput("midrst_ok", WW'(rsp_ok), WW'(0));
        checkOutput("midrst_locked", WW'(locked_out), WW'(0));
        checkOutput("midrst_words", unlock_words, WW'(0));
        tick();
        rst = 1'b0;
        checkOutput("midrst_ready", WW'(req_ready), WW'(1));
        flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid !== 1'b0) flag = 1'b0;
        end
        checkOutput("midrst_noresp", WW'(flag), WW'(1));
        checkOutput("midrst_words_after", unlock_words, WW'(0));
        checkOutput("midrst_ready_after", WW'(req_ready), WW'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_jtag_unlock_seq
